// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative 8-bit multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    localparam logic       OP_MUL      = 1'b0;
    localparam logic       OP_DIV      = 1'b1;
    localparam int         CALC_CYCLES = 8;
    localparam logic [7:0] DIV0_QUO    = 8'hFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath, purely combinational.
// MUL: right-shifting shift-add; the low half of acc holds the remaining
//      multiplier bits, so acc_i[0] is the multiplier bit for this step.
// DIV: restoring division; the next dividend bit (MSB-first) is bit_i and
//      the 9-bit partial remainder is {rem_i, bit_i}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           op_i,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   rem_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic           bit_i,
    output logic [2*W-1:0] acc_o,
    output logic [W-1:0]   rem_o,
    output logic           qbit_o
);

    logic [W:0] sum;
    logic [W:0] part;
    logic       ge;

    // Single step: the op not selected passes its state through untouched.
    always_comb begin
        acc_o  = acc_i;
        rem_o  = rem_i;
        qbit_o = 1'b0;
        sum    = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, a_i} : '0);
        part   = {rem_i, bit_i};
        ge     = (part >= {1'b0, b_i});
        if (op_i == OP_MUL) begin
            // carry lands in the top bit, the consumed multiplier bit drops out
            acc_o = {sum, acc_i[W-1:1]};
        end else if (ge) begin
            // restored remainder is always below the divisor, so W bits suffice;
            // a zero divisor always subtracts, giving all-ones quotient and rem = A
            rem_o  = W'(part - {1'b0, b_i});
            qbit_o = 1'b1;
        end else begin
            rem_o  = part[W-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 8-bit unsigned multiply/divide unit. Captures operands on start,
// iterates for CALC_CYCLES cycles, then writes the low/quotient result to
// dst and the high/remainder result to dst+1 (wrapping) on two cycles.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int pw = 3,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [W-1:0]  opA,
    input  logic [W-1:0]  opB,
    input  logic [pw-1:0] dst_addr,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [pw-1:0] wr_addr,
    output logic [W-1:0]  wr_dat
);

    localparam int CW = $clog2(CALC_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CALC_CYCLES - 1);

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic            op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [pw-1:0]   dst_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    rem_q;
    logic [W-2:0]    quo_q;   // quotient bits so far; the last bit joins on the final step
    logic            busy_q;
    logic            done_q;
    logic            wr_en_q;
    logic [pw-1:0]   wr_addr_q;
    logic [W-1:0]    wr_dat_q;

    logic [2*W-1:0]  acc_d;
    logic [W-1:0]    rem_d;
    logic            qbit;
    logic [W-1:0]    quo_d;
    logic            dvd_bit;

    // Dividend bits are consumed MSB-first as the counter advances.
    assign dvd_bit = a_q[CW'(W - 1) - count_q];
    assign quo_d   = {quo_q, qbit};

    muldiv_step #(.W(W)) u_step (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .rem_i  (rem_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .bit_i  (dvd_bit),
        .acc_o  (acc_d),
        .rem_o  (rem_d),
        .qbit_o (qbit)
    );

    // Control FSM with registered outputs; reset abandons any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            dst_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CALC;
                        count_q <= '0;
                        op_q    <= op;
                        a_q     <= opA;
                        b_q     <= opB;
                        dst_q   <= dst_addr;
                        // multiplier sits in the low half and shifts out LSB-first
                        acc_q   <= {{W{1'b0}}, opB};
                        rem_q   <= '0;
                        quo_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    rem_q   <= rem_d;
                    quo_q   <= quo_d[W-2:0];
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q   <= WR_LO;
                        count_q   <= '0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= dst_q;
                        if (op_q == OP_MUL)
                            wr_dat_q <= acc_d[W-1:0];
                        else if (b_q == '0)
                            wr_dat_q <= DIV0_QUO;
                        else
                            wr_dat_q <= quo_d;
                    end
                end
                WR_LO: begin
                    state_q   <= WR_HI;
                    done_q    <= 1'b1;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= dst_q + pw'(1);
                    wr_dat_q  <= (op_q == OP_MUL) ? acc_q[2*W-1:W] : rem_q;
                end
                WR_HI: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    wr_en_q   <= 1'b0;
                    wr_addr_q <= '0;
                    wr_dat_q  <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    wr_en_q   <= 1'b0;
                    wr_addr_q <= '0;
                    wr_dat_q  <= '0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_dat  = wr_dat_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of operations with hand-computed
// results, plus sequences for ignored starts, mid-op reset and back-to-back.
module tb_muldiv_unit;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] dst;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [2:0] hi_addr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op;
    logic [7:0] opA;
    logic [7:0] opB;
    logic [2:0] dst_addr;
    logic       busy;
    logic       done;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_dat;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    vec_t vecs[9];

    muldiv_unit #(.pw(3), .W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .dst_addr (dst_addr),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_dat   (wr_dat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %h expected %h", nm, k, act, exp);
        end
    endtask

    // Expected {busy,done,wr_en,wr_addr,wr_dat} k cycles after the launch cycle.
    task automatic check_phase(input string nm, input int k, input vec_t v);
        logic [13:0] e;
        if (k <= 8)       e = {1'b1, 1'b0, 1'b0, 3'd0, 8'h00};
        else if (k == 9)  e = {1'b1, 1'b0, 1'b1, v.dst, v.lo};
        else if (k == 10) e = {1'b1, 1'b1, 1'b1, v.hi_addr, v.hi};
        else              e = {1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        chk(nm, k, 32'({busy, done, wr_en, wr_addr, wr_dat}), 32'(e));
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        start    = 1'b1;
        op       = v.op;
        opA      = v.a;
        opB      = v.b;
        dst_addr = v.dst;
    endtask

    // Full operation; operands are scrambled after launch, optional stray starts.
    task automatic run_op(input string nm, input vec_t v, input bit pulses);
        launch(v);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                opA      = ~v.a;
                opB      = ~v.b;
                dst_addr = ~v.dst;
                op       = ~v.op;
            end
            start = pulses && (k == 3 || k == 9);
            check_phase(nm, k, v);
        end
        start = 1'b0;
    endtask

    // Reset asserted mid-cycle k after launch; no further writes may appear.
    task automatic reset_mid(input string nm, input vec_t v, input int rk);
        int snap;
        launch(v);
        for (int k = 1; k <= rk; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check_phase(nm, k, v);
        end
        #2 reset = 1'b1;
        #1 chk({nm, "_now"}, rk, 32'({busy, done, wr_en, wr_addr, wr_dat}), 32'd0);
        snap = wr_cnt;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk({nm, "_nowr"}, rk, 32'(wr_cnt), 32'(snap));
        chk({nm, "_idle"}, rk, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h0F, 8'h11, 3'd2, 8'hFF, 8'h00, 3'd3};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 3'd7, 8'h01, 8'hFE, 3'd0};
        vecs[2] = '{1'b1, 8'd200, 8'd7, 3'd4, 8'h1C, 8'h04, 3'd5};
        vecs[3] = '{1'b1, 8'h37, 8'h00, 3'd1, 8'hFF, 8'h37, 3'd2};
        vecs[4] = '{1'b0, 8'h80, 8'h02, 3'd5, 8'h00, 8'h01, 3'd6};
        vecs[5] = '{1'b0, 8'h00, 8'h5A, 3'd0, 8'h00, 8'h00, 3'd1};
        vecs[6] = '{1'b1, 8'h0A, 8'h0A, 3'd6, 8'h01, 8'h00, 3'd7};
        vecs[7] = '{1'b1, 8'h05, 8'h09, 3'd3, 8'h00, 8'h05, 3'd4};
        vecs[8] = '{1'b1, 8'hFF, 8'h01, 3'd7, 8'hFF, 8'h00, 3'd0};

        reset = 1'b1; start = 1'b0; op = 1'b0;
        opA = 8'h00; opB = 8'h00; dst_addr = 3'd0;
        @(negedge clk);
        chk("reset_state", 0, 32'({busy, done, wr_en, wr_addr, wr_dat}), 32'd0);
        start = 1'b1;
        @(negedge clk);
        chk("reset_hold", 0, 32'({busy, done, wr_en, wr_addr, wr_dat}), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset", 0, 32'({busy, done, wr_en, wr_addr, wr_dat}), 32'd0);

        for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

        // stray starts during an operation are dropped, not queued
        begin
            int snap;
            snap = wr_cnt;
            run_op("ignore_start", vecs[0], 1'b1);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                chk("ignore_idle", i, 32'({busy, wr_en}), 32'd0);
            end
            chk("ignore_wrcnt", 0, 32'(wr_cnt - snap), 32'd2);
        end

        reset_mid("rst_calc", vecs[2], 5);
        run_op("post_rst_calc", vecs[1], 1'b0);
        reset_mid("rst_wrlo", vecs[0], 9);
        run_op("post_rst_wrlo", vecs[3], 1'b0);

        // second start held from N+10; accepted at N+11, writes at N+20/N+21
        launch(vecs[4]);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 10) begin
                start    = 1'b1;
                op       = vecs[2].op;
                opA      = vecs[2].a;
                opB      = vecs[2].b;
                dst_addr = vecs[2].dst;
            end
            check_phase("b2b_first", k, vecs[4]);
        end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check_phase("b2b_second", k, vecs[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
